seq_draw_ctrl: RTL and testbench

- FSM controller that sequences the character-drawing datapath (pixel decoder, colour shifter, coordinate counter) to render one 5x5 glyph per request.
- Accepts PS/2 scan codes over a valid/ready handshake and tracks a text cursor with line wrap.
- Handles Enter (newline) and Backspace (erase).
- Emits a `plot` strobe aligned with the datapath's x/y/colour outputs for the VGA writer.

---
 rtl/seq_draw_ctrl_pkg.sv | 37 +++
 rtl/seq_draw_ctrl_cursor_tracker.sv | 67 ++++++
 rtl/seq_draw_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_seq_draw_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_draw_ctrl_pkg.sv
// Shared types and constants for the glyph-drawing sequencer: FSM states,
// cursor operations, scan codes, background colour and default geometry.
package seq_draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BACK,
        ST_CLEAR,
        ST_LOAD,
        ST_DRAW,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CUR_HOLD,
        CUR_LOAD,
        CUR_ADVANCE,
        CUR_NEWLINE,
        CUR_BACK
    } cur_op_t;

    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_BLANK  = 8'h00;
    localparam logic [5:0] COLOUR_BG = 6'b111111;

    localparam int DEF_X_ORIGIN   = 4;
    localparam int DEF_Y_ORIGIN   = 4;
    localparam int DEF_CHAR_PITCH = 24;
    localparam int DEF_LINE_PITCH = 24;
    localparam int DEF_X_LIMIT    = 296;
    localparam int DEF_Y_LIMIT    = 212;
    localparam int DEF_PLOT_LAT   = 1;
    localparam int DEF_PIXELS     = 25;

endpackage

// File: rtl/seq_draw_ctrl_cursor_tracker.sv
// Text cursor register: load, advance with line/screen wrap, newline and
// saturating backspace. All wrap arithmetic is done at 10 bits.
module cursor_tracker
    import seq_draw_pkg::*;
#(
    parameter int X_ORIGIN   = DEF_X_ORIGIN,
    parameter int Y_ORIGIN   = DEF_Y_ORIGIN,
    parameter int CHAR_PITCH = DEF_CHAR_PITCH,
    parameter int LINE_PITCH = DEF_LINE_PITCH,
    parameter int X_LIMIT    = DEF_X_LIMIT,
    parameter int Y_LIMIT    = DEF_Y_LIMIT
) (
    input  logic       clk,
    input  logic       rst,
    input  cur_op_t    i_op,
    input  logic [8:0] i_ld_x,
    input  logic [8:0] i_ld_y,
    output logic [8:0] o_x,
    output logic [8:0] o_y
);

    logic [8:0] r_x, r_y;
    logic [9:0] w_nx, w_ny;
    logic [8:0] w_adv_y;

    assign w_nx    = {1'b0, r_x} + 10'(CHAR_PITCH);
    assign w_ny    = {1'b0, r_y} + 10'(LINE_PITCH);
    assign w_adv_y = (w_ny > 10'(Y_LIMIT)) ? 9'(Y_ORIGIN) : w_ny[8:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= 9'(X_ORIGIN);
            r_y <= 9'(Y_ORIGIN);
        end else begin
            case (i_op)
                CUR_LOAD: begin
                    r_x <= i_ld_x;
                    r_y <= i_ld_y;
                end
                CUR_ADVANCE: begin
                    if (w_nx > 10'(X_LIMIT)) begin
                        r_x <= 9'(X_ORIGIN);
                        r_y <= w_adv_y;
                    end else begin
                        r_x <= w_nx[8:0];
                    end
                end
                CUR_NEWLINE: begin
                    r_x <= 9'(X_ORIGIN);
                    r_y <= w_adv_y;
                end
                CUR_BACK: begin
                    // Backspace stops at the first column rather than underflowing.
                    if ({1'b0, r_x} >= 10'(X_ORIGIN + CHAR_PITCH))
                        r_x <= r_x - 9'(CHAR_PITCH);
                end
                default: ;
            endcase
        end
    end

    assign o_x = r_x;
    assign o_y = r_y;

endmodule

// File: rtl/seq_draw_ctrl.sv
// Glyph-drawing sequencer: accepts scan codes, steps the pixel datapath and
// tracks the cursor. Optional macro SEQ_DRAW_TRANSPARENT_EN skips background pixels.
module seq_draw_ctrl
    import seq_draw_pkg::*;
#(
    parameter int X_ORIGIN   = DEF_X_ORIGIN,
    parameter int Y_ORIGIN   = DEF_Y_ORIGIN,
    parameter int CHAR_PITCH = DEF_CHAR_PITCH,
    parameter int LINE_PITCH = DEF_LINE_PITCH,
    parameter int X_LIMIT    = DEF_X_LIMIT,
    parameter int Y_LIMIT    = DEF_Y_LIMIT,
    parameter int PLOT_LAT   = DEF_PLOT_LAT,
    parameter int PIXELS     = DEF_PIXELS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_code,
    input  logic       cursor_ld,
    input  logic [8:0] cursor_x,
    input  logic [8:0] cursor_y,
    input  logic [5:0] colour_in,
    output logic [7:0] address,
    output logic       ld_colour,
    output logic       next_colour,
    output logic       ld_value,
    output logic       reset_counter,
    output logic       enable_counter,
    output logic [8:0] x_input,
    output logic [8:0] y_input,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(PIXELS + PLOT_LAT + 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_pix_cnt;
    logic [7:0]          r_address;
    logic                r_newline, r_erase;
    logic                r_ld_colour, r_next_colour, r_ld_value;
    logic                r_reset_counter, r_enable_counter, r_done;
    logic [PLOT_LAT-1:0] r_plot_pipe;
    cur_op_t             w_cur_op;
    logic                w_handshake;

    assign req_ready   = (r_state == ST_IDLE) && !cursor_ld;
    assign w_handshake = req_valid && req_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_cur_op = CUR_HOLD;
        case (r_state)
            ST_IDLE: if (cursor_ld) w_cur_op = CUR_LOAD;
            ST_BACK: w_cur_op = CUR_BACK;
            ST_DONE: begin
                if (r_newline)     w_cur_op = CUR_NEWLINE;
                else if (!r_erase) w_cur_op = CUR_ADVANCE;
            end
            default: ;
        endcase
    end

    cursor_tracker #(
        .X_ORIGIN  (X_ORIGIN),
        .Y_ORIGIN  (Y_ORIGIN),
        .CHAR_PITCH(CHAR_PITCH),
        .LINE_PITCH(LINE_PITCH),
        .X_LIMIT   (X_LIMIT),
        .Y_LIMIT   (Y_LIMIT)
    ) u_cursor (
        .clk   (clk),
        .rst   (rst),
        .i_op  (w_cur_op),
        .i_ld_x(cursor_x),
        .i_ld_y(cursor_y),
        .o_x   (x_input),
        .o_y   (y_input)
    );

    // Strobes are registered alongside the state, so each strobe is high
    // exactly during the cycles its state is resident.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_pix_cnt        <= '0;
            r_address        <= SC_BLANK;
            r_newline        <= 1'b0;
            r_erase          <= 1'b0;
            r_ld_colour      <= 1'b0;
            r_next_colour    <= 1'b0;
            r_ld_value       <= 1'b0;
            r_reset_counter  <= 1'b0;
            r_enable_counter <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_ld_colour     <= 1'b0;
            r_ld_value      <= 1'b0;
            r_reset_counter <= 1'b0;
            r_done          <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_address <= req_code;
                        r_newline <= 1'b0;
                        r_erase   <= 1'b0;
                        if (req_code == SC_ENTER) begin
                            r_newline <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= ST_DONE;
                        end else if (req_code == SC_BKSP) begin
                            r_address <= SC_BLANK;
                            r_erase   <= 1'b1;
                            r_state   <= ST_BACK;
                        end else begin
                            r_reset_counter <= 1'b1;
                            r_state         <= ST_CLEAR;
                        end
                    end
                end
                ST_BACK: begin
                    r_reset_counter <= 1'b1;
                    r_state         <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    r_ld_value  <= 1'b1;
                    r_ld_colour <= 1'b1;
                    r_state     <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_pix_cnt        <= '0;
                    r_enable_counter <= 1'b1;
                    r_next_colour    <= 1'b1;
                    r_state          <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (r_pix_cnt == CNT_W'(PIXELS - 1)) begin
                        r_pix_cnt        <= '0;
                        r_enable_counter <= 1'b0;
                        r_next_colour    <= 1'b0;
                        r_state          <= ST_DRAIN;
                    end else begin
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_pix_cnt == CNT_W'(PLOT_LAT - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // plot tracks enable_counter through the datapath's output latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_plot_pipe <= '0;
        end else begin
            r_plot_pipe[0] <= r_enable_counter;
            for (int i = 1; i < PLOT_LAT; i++)
                r_plot_pipe[i] <= r_plot_pipe[i-1];
        end
    end

`ifdef SEQ_DRAW_TRANSPARENT_EN
    assign plot = r_plot_pipe[PLOT_LAT-1] && (r_erase || (colour_in != COLOUR_BG));
`else
    logic w_unused_colour;
    assign w_unused_colour = ^colour_in;
    assign plot            = r_plot_pipe[PLOT_LAT-1];
`endif

    assign address        = r_address;
    assign ld_colour      = r_ld_colour;
    assign next_colour    = r_next_colour;
    assign ld_value       = r_ld_value;
    assign reset_counter  = r_reset_counter;
    assign enable_counter = r_enable_counter;
    assign busy           = (r_state != ST_IDLE);
    assign done           = r_done;

endmodule

// File: tb/tb_seq_draw_ctrl.sv
// Self-checking bench for seq_draw_ctrl: directed cases plus random requests
// compared against a timeline/cursor model derived from the drawing rules.
module tb_seq_draw_ctrl;

    localparam int X0 = 4, Y0 = 4, CP = 24, LP = 24, XL = 296, YL = 212;
    localparam logic [5:0] BG = 6'b111111;

    logic       clk = 1'b0;
    logic       rst, req_valid, req_ready, cursor_ld;
    logic [7:0] req_code, address;
    logic [8:0] cursor_x, cursor_y, x_input, y_input;
    logic [5:0] colour_in;
    logic       ld_colour, next_colour, ld_value, reset_counter, enable_counter;
    logic       plot, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int mx = X0, my = Y0;

    always #5 clk = ~clk;

    seq_draw_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_code(req_code), .cursor_ld(cursor_ld), .cursor_x(cursor_x),
        .cursor_y(cursor_y), .colour_in(colour_in), .address(address),
        .ld_colour(ld_colour), .next_colour(next_colour), .ld_value(ld_value),
        .reset_counter(reset_counter), .enable_counter(enable_counter),
        .x_input(x_input), .y_input(y_input), .plot(plot), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int adv_y(input int y);
        return (y + LP > YL) ? Y0 : y + LP;
    endfunction

    task automatic load_cursor(input int x, input int y);
        cursor_ld = 1'b1; cursor_x = 9'(x); cursor_y = 9'(y);
        step();
        cursor_ld = 1'b0;
        mx = x; my = y;
    endtask

    // Offer one code, record the whole transaction and compare it with the
    // timeline expected for its kind (character, backspace, enter).
    task automatic send(input logic [7:0] code, input string name);
        bit is_enter = (code == 8'h5A);
        bit is_bksp  = (code == 8'h66);
        int b = is_bksp ? 1 : 0;
        int ex = mx, ey = my;
        int exp_addr = is_bksp ? 0 : int'(code);
        int done_c = 0, n_rc = 0, rc_c = 0, n_ld = 0, ld_c = 0, n_en = 0, first_en = 0;
        int n_plot = 0, exp_n_plot = 0, plot_bad = 0, excl = 0, pair_bad = 0;
        int addr_bad = 0, pos_bad = 0, busy_bad = 0;
        bit in_win, gate, exp_plot;
        if (is_bksp && mx >= X0 + CP) ex = mx - CP;

        req_code = code; req_valid = 1'b1;
        #1 check({name, "_ready"}, 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            colour_in = (c % 2 == 1) ? BG : 6'h15;
            #1;
            in_win = !is_enter && c >= 4 + b && c <= 28 + b;
`ifdef SEQ_DRAW_TRANSPARENT_EN
            gate = is_bksp || (colour_in != BG);
`else
            gate = 1'b1;
`endif
            exp_plot = in_win && gate;
            if (exp_plot) exp_n_plot++;
            if (plot !== exp_plot) plot_bad++;
            if (plot === 1'b1) n_plot++;
            if (reset_counter === 1'b1) begin n_rc++; rc_c = c; end
            if (ld_value === 1'b1 && ld_colour === 1'b1) begin n_ld++; ld_c = c; end
            if (ld_value !== ld_colour || enable_counter !== next_colour) pair_bad++;
            if (enable_counter === 1'b1) begin n_en++; if (first_en == 0) first_en = c; end
            if (reset_counter === 1'b1 && (ld_value === 1'b1 || enable_counter === 1'b1)) excl++;
            if (address !== 8'(exp_addr)) addr_bad++;
            if (c >= 1 + b && (x_input !== 9'(ex) || y_input !== 9'(ey))) pos_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) done_c = c;
            else step();
        end

        check({name, "_done_cycle"}, done_c, is_enter ? 1 : 29 + b);
        check({name, "_n_reset_counter"}, n_rc, is_enter ? 0 : 1);
        check({name, "_n_ld_value"}, n_ld, is_enter ? 0 : 1);
        check({name, "_n_enable"}, n_en, is_enter ? 0 : 25);
        check({name, "_n_plot"}, n_plot, exp_n_plot);
        check({name, "_plot_timing"}, plot_bad, 0);
        check({name, "_strobe_excl"}, excl, 0);
        check({name, "_strobe_pairs"}, pair_bad, 0);
        check({name, "_address"}, addr_bad, 0);
        check({name, "_draw_pos"}, pos_bad, 0);
        check({name, "_busy"}, busy_bad, 0);
        if (!is_enter) begin
            check({name, "_rc_cycle"}, rc_c, 1 + b);
            check({name, "_ld_cycle"}, ld_c, 2 + b);
            check({name, "_first_enable"}, first_en, 3 + b);
        end

        if (is_enter) begin
            mx = X0; my = adv_y(my);
        end else if (is_bksp) begin
            mx = ex;
        end else if (mx + CP > XL) begin
            mx = X0; my = adv_y(my);
        end else begin
            mx = mx + CP;
        end
        step();
        check({name, "_idle_busy"}, 32'(busy), 0);
        check({name, "_idle_done"}, 32'(done), 0);
        check({name, "_cursor_x"}, 32'(x_input), mx);
        check({name, "_cursor_y"}, 32'(y_input), my);
    endtask

    initial begin
        logic [7:0] rc;
        rst = 1'b1; req_valid = 1'b0; req_code = 8'h00; cursor_ld = 1'b0;
        cursor_x = '0; cursor_y = '0; colour_in = '0;
        step(); step();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_plot", 32'(plot), 0);
        check("rst_address", 32'(address), 0);
        check("rst_strobes", 32'({ld_colour, next_colour, ld_value, reset_counter, enable_counter}), 0);
        check("rst_cursor_x", 32'(x_input), X0);
        check("rst_cursor_y", 32'(y_input), Y0);
        rst = 1'b0;
        step();

        send(8'h1C, "t1_char");          // expect cursor (28,4)
        check("t1_x28", 32'(x_input), 28);

        load_cursor(292, 100);
        send(8'h16, "t2_linewrap");      // expect (4,124)
        check("t2_y124", 32'(y_input), 124);

        load_cursor(4, 212);
        send(8'h5A, "t3_screenwrap");    // expect (4,4)

        load_cursor(52, 4);
        send(8'h66, "t4_bksp");          // erase at (28,4)
        load_cursor(4, 4);
        send(8'h66, "t4_bksp_origin");   // no underflow

        // Mid-draw reset at DRAW pixel 10 (cycle 13 after handshake).
        load_cursor(100, 76);
        req_code = 8'h1C; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("t5_in_draw", 32'(enable_counter), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_abort_outs", 32'({ld_colour, next_colour, ld_value, reset_counter,
                                     enable_counter, plot, busy, done}), 0);
        check("t5_abort_addr", 32'(address), 0);
        check("t5_abort_x", 32'(x_input), X0);
        check("t5_abort_y", 32'(y_input), Y0);
        mx = X0; my = Y0;
        step();
        check("t5_no_late_plot", 32'(plot), 0);

        // cursor_ld and req_valid together: load wins, request held one cycle.
        cursor_ld = 1'b1; cursor_x = 9'd100; cursor_y = 9'd50;
        req_code = 8'h1C; req_valid = 1'b1;
        #1 check("t5_ready_low", 32'(req_ready), 0);
        step();
        cursor_ld = 1'b0;
        check("t5_held_busy", 32'(busy), 0);
        check("t5_loaded_x", 32'(x_input), 100);
        check("t5_loaded_y", 32'(y_input), 50);
        mx = 100; my = 50;
        send(8'h1C, "t5_held_req");

        // Random mix of characters, enters, backspaces and cursor loads.
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 3) == 0)
                load_cursor(int'($urandom_range(X0, XL)), int'($urandom_range(Y0, YL)));
            case ($urandom_range(0, 5))
                0:       rc = 8'h5A;
                1:       rc = 8'h66;
                default: rc = 8'($urandom_range(0, 255));
            endcase
            send(rc, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
